// File: rtl/mux_pipeline_stream.sv
// mux_pipeline_stream: RADIX-ary select tree, one register rank per level.
// Optional out_sel echo port: define MUX_PIPELINE_STREAM_SEL_ECHO_EN.
module mux_pipeline_stream #(
  parameter int WIDTH = 8,
  parameter int INPUT_COUNT = 8,
  parameter int RADIX = 2,
  localparam int SEL_W = $clog2(INPUT_COUNT)
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         in_valid,
  output logic                         in_ready,
  input  logic [SEL_W-1:0]             sel,
  input  logic [WIDTH*INPUT_COUNT-1:0] in,
  output logic                         out_valid,
  input  logic                         out_ready,
`ifdef MUX_PIPELINE_STREAM_SEL_ECHO_EN
  output logic [SEL_W-1:0]             out_sel,
`endif
  output logic [WIDTH-1:0]             out
);

  localparam int RSEL_W = $clog2(RADIX);
  localparam int STG_R = (SEL_W + RSEL_W - 1) / RSEL_W;
  localparam int STAGES = (STG_R < 1) ? 1 : STG_R;
  localparam int SELP_W = RSEL_W * STAGES;
  localparam int NPAD = 1 << SELP_W;

  logic [STAGES-1:0]     valid_q;
  logic [STAGES-1:0]     valid_d;
  logic [STAGES-1:0]     upv;
  logic [STAGES-1:0]     load;
  logic [STAGES:0]       rdy;
  logic [SELP_W-1:0]     selp;
  logic [WIDTH*NPAD-1:0] in_pad;

  // Missing words and high select bits read as zero, so
  // out-of-range selects land on zero padding.
  assign selp   = SELP_W'(sel);
  assign in_pad = (WIDTH*NPAD)'(in);

  // Ready ripples back from the consumer; empty stages always accept.
  always_comb begin
    rdy = '0;
    rdy[STAGES] = out_ready;
    for (int k = STAGES - 1; k >= 0; k--) begin
      rdy[k] = !valid_q[k] || rdy[k+1];
    end
  end

  always_comb begin
    upv = '0;
    upv[0] = in_valid;
    for (int k = 1; k < STAGES; k++) begin
      upv[k] = valid_q[k-1];
    end
  end

  always_comb begin
    load    = upv & rdy[STAGES-1:0];
    valid_d = valid_q;
    for (int k = 0; k < STAGES; k++) begin
      if (rdy[k]) valid_d[k] = upv[k];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) valid_q <= '0;
    else        valid_q <= valid_d;
  end

  for (genvar k = 0; k < STAGES; k++) begin : g_stg
    localparam int NW = RADIX ** (STAGES - 1 - k);
    localparam int UW = RSEL_W * (STAGES - k);

    logic [NW*RADIX*WIDTH-1:0] up_w;
    logic [UW-1:0]             up_s;
    logic [NW*WIDTH-1:0]       data_d;
    logic [NW*WIDTH-1:0]       data_q;

    if (k == 0) begin : g_src
      assign up_w = in_pad;
      assign up_s = selp;
    end else begin : g_src
      assign up_w = g_stg[k-1].data_q;
      assign up_s = g_stg[k-1].g_res.res_q;
    end

    always_comb begin
      data_d = '0;
      for (int j = 0; j < NW; j++) begin
        data_d[j*WIDTH +: WIDTH] =
          up_w[(j*RADIX + int'(up_s[RSEL_W-1:0]))*WIDTH +: WIDTH];
      end
    end

    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)       data_q <= '0;
      else if (load[k]) data_q <= data_d;
    end

    if (UW > RSEL_W) begin : g_res
      logic [UW-RSEL_W-1:0] res_q;

      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)       res_q <= '0;
        else if (load[k]) res_q <= up_s[UW-1:RSEL_W];
      end
    end
  end

  assign in_ready  = rdy[0];
  assign out_valid = valid_q[STAGES-1];
  assign out       = g_stg[STAGES-1].data_q;

`ifdef MUX_PIPELINE_STREAM_SEL_ECHO_EN
  logic [SEL_W-1:0] esel_q [STAGES];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int k = 0; k < STAGES; k++) esel_q[k] <= '0;
    end else begin
      if (load[0]) esel_q[0] <= sel;
      for (int k = 1; k < STAGES; k++) begin
        if (load[k]) esel_q[k] <= esel_q[k-1];
      end
    end
  end

  assign out_sel = esel_q[STAGES-1];
`endif

endmodule

// File: tb/tb_mux_pipeline_stream.sv
// tb_mux_pipeline_stream: directed and random checks on three tree shapes.
// Instances: 8 inputs radix 2, 5 inputs radix 4, 8 inputs radix 8.
module tb_mux_pipeline_stream;

  localparam logic [63:0] PAT = 64'h1716151413121110;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [2:0] iv;
  logic [2:0] ordy;
  logic [2:0] sl [3];
  logic [63:0] iw [3];
  wire  [2:0] ir;
  wire  [2:0] ov;
  wire  [7:0] ow [3];
`ifdef MUX_PIPELINE_STREAM_SEL_ECHO_EN
  wire  [2:0] os [3];
`endif

  int n_run = 0;
  int n_fail = 0;
  int stg [3] = '{3, 2, 1};
  int nin [3] = '{8, 5, 8};
  int occ [3];
  logic [10:0] sb [3][$];

  always #5 clk = ~clk;

  mux_pipeline_stream #(.WIDTH(8), .INPUT_COUNT(8), .RADIX(2)) u_r2 (
    .clk(clk), .rst_n(rst_n),
    .in_valid(iv[0]), .in_ready(ir[0]),
    .sel(sl[0]), .in(iw[0]),
    .out_valid(ov[0]), .out_ready(ordy[0]),
`ifdef MUX_PIPELINE_STREAM_SEL_ECHO_EN
    .out_sel(os[0]),
`endif
    .out(ow[0])
  );

  mux_pipeline_stream #(.WIDTH(8), .INPUT_COUNT(5), .RADIX(4)) u_r4 (
    .clk(clk), .rst_n(rst_n),
    .in_valid(iv[1]), .in_ready(ir[1]),
    .sel(sl[1]), .in(iw[1][39:0]),
    .out_valid(ov[1]), .out_ready(ordy[1]),
`ifdef MUX_PIPELINE_STREAM_SEL_ECHO_EN
    .out_sel(os[1]),
`endif
    .out(ow[1])
  );

  mux_pipeline_stream #(.WIDTH(8), .INPUT_COUNT(8), .RADIX(8)) u_r8 (
    .clk(clk), .rst_n(rst_n),
    .in_valid(iv[2]), .in_ready(ir[2]),
    .sel(sl[2]), .in(iw[2]),
    .out_valid(ov[2]), .out_ready(ordy[2]),
`ifdef MUX_PIPELINE_STREAM_SEL_ECHO_EN
    .out_sel(os[2]),
`endif
    .out(ow[2])
  );

  function automatic logic [7:0] pick(int d, logic [63:0] w,
                                      logic [2:0] s);
    return (int'(s) < nin[d]) ? w[int'(s)*8 +: 8] : 8'h00;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    iv = '0;
    ordy = '0;
    for (int d = 0; d < 3; d++) begin
      sl[d] = '0;
      iw[d] = PAT;
    end
    repeat (3) tick();
    rst_n = 1'b1;
    #1;
    for (int d = 0; d < 3; d++) begin
      n_run += 3;
      if (ov[d] !== 1'b0) begin
        n_fail++;
        $display("FAIL reset_ov[%0d]: got %b want 0", d, ov[d]);
      end
      if (ow[d] !== 8'h00) begin
        n_fail++;
        $display("FAIL reset_out[%0d]: got %h want 00", d, ow[d]);
      end
      if (ir[d] !== 1'b1) begin
        n_fail++;
        $display("FAIL reset_ir[%0d]: got %b want 1", d, ir[d]);
      end
`ifdef MUX_PIPELINE_STREAM_SEL_ECHO_EN
      n_run++;
      if (os[d] !== 3'd0) begin
        n_fail++;
        $display("FAIL reset_sel[%0d]: got %0d want 0", d, os[d]);
      end
`endif
    end
    for (int c = 0; c < 3; c++) begin
      iv[0] = 1'b1;
      sl[0] = 3'(c + 1);
      tick();
    end
    iv[0] = 1'b0;
    #1;
    n_run++;
    if (ov[0] !== 1'b1 || ow[0] !== 8'h11) begin
      n_fail++;
      $display("FAIL inflight: got v=%b %h want v=1 11", ov[0], ow[0]);
    end
    rst_n = 1'b0;
    #1;
    n_run += 2;
    if (ov[0] !== 1'b0) begin
      n_fail++;
      $display("FAIL async_clr_ov: got %b want 0", ov[0]);
    end
    if (ow[0] !== 8'h00) begin
      n_fail++;
      $display("FAIL async_clr_out: got %h want 00", ow[0]);
    end
    tick();
    rst_n = 1'b1;
    ordy = '1;
    #1;
    n_run++;
    if (ir[0] !== 1'b1) begin
      n_fail++;
      $display("FAIL post_rst_ir: got %b want 1", ir[0]);
    end
    for (int c = 0; c < 5; c++) begin
      tick();
      n_run++;
      if (ov[0] !== 1'b0) begin
        n_fail++;
        $display("FAIL stale_out c=%0d: got v=%b want 0", c, ov[0]);
      end
    end
  endtask

  task automatic test_stream();
    logic       ev;
    logic [2:0] k;
    for (int c = 0; c < 12; c++) begin
      for (int d = 0; d < 3; d++) begin
        iv[d] = (c < 8);
        sl[d] = 3'(c);
        iw[d] = PAT;
        ordy[d] = 1'b1;
      end
      #1;
      for (int d = 0; d < 3; d++) begin
        ev = (c >= stg[d]) && (c < stg[d] + 8);
        k = 3'(c - stg[d]);
        n_run++;
        if (ov[d] !== ev) begin
          n_fail++;
          $display("FAIL stream_v[%0d] c=%0d: got %b want %b",
                   d, c, ov[d], ev);
        end
        if (ev) begin
          n_run++;
          if (ow[d] !== pick(d, PAT, k)) begin
            n_fail++;
            $display("FAIL stream_out[%0d] c=%0d: got %h want %h",
                     d, c, ow[d], pick(d, PAT, k));
          end
`ifdef MUX_PIPELINE_STREAM_SEL_ECHO_EN
          n_run++;
          if (os[d] !== k) begin
            n_fail++;
            $display("FAIL stream_sel[%0d] c=%0d: got %0d want %0d",
                     d, c, os[d], k);
          end
`endif
        end
        if (c < 8) begin
          n_run++;
          if (ir[d] !== 1'b1) begin
            n_fail++;
            $display("FAIL stream_ir[%0d] c=%0d: got %b want 1",
                     d, c, ir[d]);
          end
        end
      end
      tick();
    end
  endtask

  task automatic test_backpressure();
    logic [7:0] seq [4];
    logic       ev;
    logic       er;
    logic [7:0] ew;
    seq = '{8'h15, 8'h12, 8'h17, 8'h10};
    iv = '0;
    ordy = '1;
    iw[0] = PAT;
    for (int c = 0; c < 13; c++) begin
      iv[0] = (c <= 8);
      sl[0] = (c == 0) ? 3'd5 : (c == 1) ? 3'd2 : (c == 2) ? 3'd7 : 3'd0;
      ordy[0] = (c >= 8);
      #1;
      if (c <= 8) begin
        er = (c < 3) || (c == 8);
        n_run++;
        if (ir[0] !== er) begin
          n_fail++;
          $display("FAIL bp_ir c=%0d: got %b want %b", c, ir[0], er);
        end
      end
      ev = (c >= 3) && (c <= 11);
      n_run++;
      if (ov[0] !== ev) begin
        n_fail++;
        $display("FAIL bp_v c=%0d: got %b want %b", c, ov[0], ev);
      end
      if (ev) begin
        ew = seq[(c <= 8) ? 0 : c - 8];
        n_run++;
        if (ow[0] !== ew) begin
          n_fail++;
          $display("FAIL bp_out c=%0d: got %h want %h", c, ow[0], ew);
        end
      end
      tick();
    end
  endtask

  task automatic test_bubbles();
    logic [10:0] e;
    logic        er;
    occ[0] = 0;
    sb[0].delete();
    iw[0] = PAT;
    for (int c = 0; c < 60; c++) begin
      iv[0] = (c < 45) && (c % 3 == 0);
      sl[0] = 3'(c / 3 * 5 + 1);
      ordy[0] = (c % 2 == 0) || (c >= 45);
      #1;
      er = (occ[0] < 3) || ordy[0];
      n_run++;
      if (ir[0] !== er) begin
        n_fail++;
        $display("FAIL bub_ir c=%0d: got %b want %b", c, ir[0], er);
      end
      if (ov[0] && ordy[0]) begin
        n_run++;
        if (sb[0].size() == 0) begin
          n_fail++;
          $display("FAIL bub_extra c=%0d: got %h want none", c, ow[0]);
        end else begin
          e = sb[0].pop_front();
          occ[0]--;
          if (ow[0] !== e[7:0]) begin
            n_fail++;
            $display("FAIL bub_out c=%0d: got %h want %h",
                     c, ow[0], e[7:0]);
          end
        end
      end
      if (iv[0] && ir[0]) begin
        sb[0].push_back({sl[0], pick(0, PAT, sl[0])});
        occ[0]++;
      end
      tick();
    end
    n_run++;
    if (sb[0].size() != 0) begin
      n_fail++;
      $display("FAIL bub_lost: got %0d left want 0", sb[0].size());
    end
  endtask

  task automatic test_random();
    logic [10:0] e;
    logic        er;
    logic [2:0]  hv;
    logic [7:0]  hw [3];
    hv = '0;
    for (int d = 0; d < 3; d++) begin
      occ[d] = 0;
      sb[d].delete();
    end
    for (int c = 0; c < 900; c++) begin
      for (int d = 0; d < 3; d++) begin
        iv[d] = (c < 800) && ($urandom_range(0, 3) != 0);
        sl[d] = 3'($urandom_range(0, 7));
        iw[d] = {$urandom, $urandom};
        ordy[d] = (c >= 800) || ($urandom_range(0, 2) != 0);
      end
      #1;
      for (int d = 0; d < 3; d++) begin
        er = (occ[d] < stg[d]) || ordy[d];
        n_run++;
        if (ir[d] !== er) begin
          n_fail++;
          $display("FAIL rnd_ir[%0d] c=%0d: got %b want %b",
                   d, c, ir[d], er);
        end
        if (hv[d]) begin
          n_run++;
          if (ov[d] !== 1'b1 || ow[d] !== hw[d]) begin
            n_fail++;
            $display("FAIL rnd_hold[%0d] c=%0d: got %b %h want 1 %h",
                     d, c, ov[d], ow[d], hw[d]);
          end
        end
        hv[d] = ov[d] && !ordy[d];
        hw[d] = ow[d];
        if (ov[d] && ordy[d]) begin
          n_run++;
          if (sb[d].size() == 0) begin
            n_fail++;
            $display("FAIL rnd_extra[%0d] c=%0d: got %h want none",
                     d, c, ow[d]);
          end else begin
            e = sb[d].pop_front();
            occ[d]--;
            if (ow[d] !== e[7:0]) begin
              n_fail++;
              $display("FAIL rnd_out[%0d] c=%0d: got %h want %h",
                       d, c, ow[d], e[7:0]);
            end
`ifdef MUX_PIPELINE_STREAM_SEL_ECHO_EN
            n_run++;
            if (os[d] !== e[10:8]) begin
              n_fail++;
              $display("FAIL rnd_sel[%0d] c=%0d: got %0d want %0d",
                       d, c, os[d], e[10:8]);
            end
`endif
          end
        end
        if (iv[d] && ir[d]) begin
          sb[d].push_back({sl[d], pick(d, iw[d], sl[d])});
          occ[d]++;
        end
      end
      tick();
    end
    for (int d = 0; d < 3; d++) begin
      n_run++;
      if (sb[d].size() != 0) begin
        n_fail++;
        $display("FAIL rnd_lost[%0d]: got %0d left want 0",
                 d, sb[d].size());
      end
    end
  endtask

  initial begin
    test_reset();
    test_stream();
    test_backpressure();
    test_bubbles();
    test_random();
    $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
    $finish;
  end

endmodule
